// File: rtl/masked_subbytes_ctrl_pkg.sv
// Shared definitions for the masked SubBytes sequencer: FSM encoding,
// byte count and the {valid, tag} entry carried alongside the sbox pipeline.
package masked_subbytes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    localparam int unsigned NUM_BYTES = 16;
    localparam int unsigned TAG_W     = 4;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/masked_subbytes_ctrl_tag_delay_line.sv
// Fixed-depth shift register that tracks which byte is in flight inside the
// external masked sbox; it advances every cycle independent of the FSM.
module tag_delay_line
    import masked_subbytes_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned WIDTH = 5
) (
    input  logic             ClkxCI,
    input  logic             RstxRI,
    input  logic [WIDTH-1:0] DataxDI,
    output logic [WIDTH-1:0] DataxDO
);

    logic [WIDTH-1:0] pipe_r [DEPTH];

    // Shift register stages, cleared on reset so no stale tag survives it
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pipe_r[0] <= DataxDI;
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign DataxDO = pipe_r[DEPTH-1];

endmodule

// File: rtl/masked_subbytes_ctrl.sv
// Feeds the 16 shared state bytes through an external pipelined masked sbox,
// throttled by randomness availability, and reassembles the shared results.
module masked_subbytes_ctrl
    import masked_subbytes_ctrl_pkg::*;
#(
    parameter int unsigned SHARES       = 2,
    parameter int unsigned SBOX_LATENCY = 5
) (
    input  logic                    ClkxCI,
    input  logic                    RstxRI,
    input  logic                    StartxSI,
    input  logic [128*SHARES-1:0]   StatexDI,
    input  logic                    RndValidxSI,
    output logic                    RndReqxSO,
    output logic [8*SHARES-1:0]     SboxInxDO,
    input  logic [8*SHARES-1:0]     SboxOutxDI,
    output logic [128*SHARES-1:0]   StatexDO,
    output logic                    BusyxSO,
    output logic                    DonexSO
);

    localparam int unsigned STATE_W = 128 * SHARES;
    localparam int unsigned ENTRY_W = TAG_W + 1;

    ctrl_state_e          state_r;
    logic [STATE_W-1:0]   stateIn_r;
    logic [STATE_W-1:0]   result_r;
    logic [TAG_W-1:0]     issueCnt_r;
    logic [TAG_W-1:0]     captCnt_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 rndReq_r;

    logic                 issue_s;
    logic [8*SHARES-1:0]  sboxIn_s;
    tag_entry_t           tagIn_s;
    tag_entry_t           tagOut_s;
    logic [ENTRY_W-1:0]   tagOutRaw_s;

    // Issue decision and operand select; a missing random word becomes a bubble
    always_comb begin
        issue_s  = 1'b0;
        sboxIn_s = {(8*SHARES){1'b0}};
        tagIn_s  = '{valid: 1'b0, tag: {TAG_W{1'b0}}};
        if ((state_r == FEED) && RndValidxSI) begin
            issue_s = 1'b1;
            tagIn_s = '{valid: 1'b1, tag: issueCnt_r};
            for (int s = 0; s < int'(SHARES); s++) begin
                sboxIn_s[s*8 +: 8] = stateIn_r[s*128 + 8*int'(issueCnt_r) +: 8];
            end
        end else begin
            issue_s  = 1'b0;
            sboxIn_s = {(8*SHARES){1'b0}};
        end
    end

    tag_delay_line #(
        .DEPTH (SBOX_LATENCY),
        .WIDTH (ENTRY_W)
    ) u_tag_delay_line (
        .ClkxCI  (ClkxCI),
        .RstxRI  (RstxRI),
        .DataxDI (tagIn_s),
        .DataxDO (tagOutRaw_s)
    );

    assign tagOut_s = tag_entry_t'(tagOutRaw_s);

    // Sequencer FSM with registered status outputs
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            state_r    <= IDLE;
            stateIn_r  <= {STATE_W{1'b0}};
            issueCnt_r <= {TAG_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rndReq_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (StartxSI) begin
                        state_r    <= FEED;
                        stateIn_r  <= StatexDI;
                        issueCnt_r <= {TAG_W{1'b0}};
                        busy_r     <= 1'b1;
                        rndReq_r   <= 1'b1;
                    end else begin
                        busy_r   <= 1'b0;
                        rndReq_r <= 1'b0;
                    end
                end
                FEED: begin
                    if (issue_s) begin
                        issueCnt_r <= issueCnt_r + 4'd1;
                        if (issueCnt_r == 4'(NUM_BYTES - 1)) begin
                            state_r  <= DRAIN;
                            rndReq_r <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (tagOut_s.valid && (captCnt_r == 4'(NUM_BYTES - 1))) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r  <= IDLE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    rndReq_r <= 1'b0;
                end
            endcase
        end
    end

    // Result capture: the tag leaving the delay line names the destination byte
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            result_r  <= {STATE_W{1'b0}};
            captCnt_r <= {TAG_W{1'b0}};
        end else if ((state_r == IDLE) && StartxSI) begin
            captCnt_r <= {TAG_W{1'b0}};
        end else if (tagOut_s.valid) begin
            for (int s = 0; s < int'(SHARES); s++) begin
                result_r[s*128 + 8*int'(tagOut_s.tag) +: 8] <= SboxOutxDI[s*8 +: 8];
            end
            captCnt_r <= captCnt_r + 4'd1;
        end
    end

    assign SboxInxDO = sboxIn_s;
    assign RndReqxSO = rndReq_r;
    assign StatexDO  = result_r;
    assign BusyxSO   = busy_r;
    assign DonexSO   = done_r;

endmodule

// File: tb/tb_masked_subbytes_ctrl.sv
// Directed bench: two controllers (2 shares/latency 5, 3 shares/latency 6)
// each driving a behavioural masked AES sbox that re-masks with fresh randomness.
module tb_masked_subbytes_ctrl;

    logic ClkxCI = 1'b0;
    always #5 ClkxCI = ~ClkxCI;

    int n_vec = 0;
    int n_err = 0;

    // DUT A: SHARES=2, SBOX_LATENCY=5
    logic         rstA, startA, rndValidA, rndReqA, busyA, doneA;
    logic [255:0] stateInA, stateOutA;
    logic [15:0]  sboxInA, sboxOutA;
    // DUT B: SHARES=3, SBOX_LATENCY=6
    logic         rstB, startB, rndValidB, rndReqB, busyB, doneB;
    logic [383:0] stateInB, stateOutB;
    logic [23:0]  sboxInB, sboxOutB;

    masked_subbytes_ctrl #(.SHARES(2), .SBOX_LATENCY(5)) dut_a (
        .ClkxCI(ClkxCI), .RstxRI(rstA), .StartxSI(startA), .StatexDI(stateInA),
        .RndValidxSI(rndValidA), .RndReqxSO(rndReqA), .SboxInxDO(sboxInA),
        .SboxOutxDI(sboxOutA), .StatexDO(stateOutA), .BusyxSO(busyA), .DonexSO(doneA)
    );

    masked_subbytes_ctrl #(.SHARES(3), .SBOX_LATENCY(6)) dut_b (
        .ClkxCI(ClkxCI), .RstxRI(rstB), .StartxSI(startB), .StatexDI(stateInB),
        .RndValidxSI(rndValidB), .RndReqxSO(rndReqB), .SboxInxDO(sboxInB),
        .SboxOutxDI(sboxOutB), .StatexDO(stateOutB), .BusyxSO(busyB), .DonexSO(doneB)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    // Behavioural masked sboxes: unmask, substitute, re-share with fresh masks
    logic [15:0] pipeA [5];
    logic [23:0] pipeB [6];
    logic [7:0]  yA, mA, yB, m1B, m2B;
    always @(posedge ClkxCI) begin
        yA  = aes_sbox(sboxInA[7:0] ^ sboxInA[15:8]);
        mA  = 8'($urandom);
        yB  = aes_sbox(sboxInB[7:0] ^ sboxInB[15:8] ^ sboxInB[23:16]);
        m1B = 8'($urandom);
        m2B = 8'($urandom);
        pipeA[0] <= {mA, yA ^ mA};
        for (int i = 1; i < 5; i++) pipeA[i] <= pipeA[i-1];
        pipeB[0] <= {m2B, m1B, yB ^ m1B ^ m2B};
        for (int i = 1; i < 6; i++) pipeB[i] <= pipeB[i-1];
    end
    assign sboxOutA = pipeA[4];
    assign sboxOutB = pipeB[5];

    task automatic check_vec(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start DUT A with st, then run until Done (bounded). Cycle n is the one after edge t0+n-1.
    task automatic run_a(input logic [255:0] st, input int bub_lo, input int bub_hi,
                         input int restart_at, input logic [255:0] st2,
                         output int done_cyc, output int bubbles, output logic [255:0] res);
        done_cyc = 0;
        bubbles  = 0;
        res      = 256'h0;
        startA    = 1'b1;
        stateInA  = st;
        rndValidA = 1'b1;
        @(posedge ClkxCI); #1;
        startA = 1'b0;
        for (int n = 1; n <= 60 && done_cyc == 0; n++) begin
            if (doneA) begin
                done_cyc = n;
                res      = stateOutA;
            end
            rndValidA = !(n >= bub_lo && n <= bub_hi);
            startA    = (n == restart_at);
            stateInA  = (n == restart_at) ? st2 : st;
            #1;
            if (!rndValidA && sboxInA == 16'h0000) bubbles++;
            if (done_cyc == 0) begin
                @(posedge ClkxCI); #1;
            end
        end
        startA    = 1'b0;
        rndValidA = 1'b1;
    endtask

    localparam logic [127:0] BASE  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] EXP1  = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] ALL53 = {16{8'h53}};
    localparam logic [127:0] ALLED = {16{8'hed}};

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int dc;
        int nb;
        int spurious;
        logic [255:0] res;
        logic [127:0] m;
        logic [127:0] m1;
        logic [127:0] m2;
        logic [383:0] resB;

        rstA = 1'b1; startA = 1'b0; rndValidA = 1'b1; stateInA = 256'h0;
        rstB = 1'b1; startB = 1'b0; rndValidB = 1'b1; stateInB = 384'h0;
        repeat (2) @(posedge ClkxCI);
        #1;
        check_vec("rst_busy",  {busyA, busyB}, 2'b00);
        check_vec("rst_done",  {doneA, doneB}, 2'b00);
        check_vec("rst_rndreq", {rndReqA, rndReqB}, 2'b00);
        check_vec("rst_sboxin", {sboxInA, sboxInB}, 40'h0);
        check_vec("rst_state_a", stateOutA, 256'h0);
        rstA = 1'b0;
        rstB = 1'b0;
        @(posedge ClkxCI); #1;

        // Plain run: share1 all-zero
        run_a({128'h0, BASE}, 0, -1, 0, 256'h0, dc, nb, res);
        check_vec("t1_done_cyc", dc, 22);
        check_vec("t1_result", res[127:0] ^ res[255:128], EXP1);
        @(posedge ClkxCI); #1;
        check_vec("t1_done_pulse", doneA, 1'b0);
        check_vec("t1_idle_busy", busyA, 1'b0);
        repeat (3) @(posedge ClkxCI);
        #1;
        check_vec("t1_hold", stateOutA, res);

        // All 0x53 under a random mask
        m = {$urandom, $urandom, $urandom, $urandom};
        run_a({m, ALL53 ^ m}, 0, -1, 0, 256'h0, dc, nb, res);
        check_vec("t2_done_cyc", dc, 22);
        check_vec("t2_result", res[127:0] ^ res[255:128], ALLED);
        check_vec("t2_remasked", res[255:128] != m, 1'b1);
        @(posedge ClkxCI); #1;

        // Randomness stalls in FEED cycles 3..5
        run_a({128'h0, BASE}, 3, 5, 0, 256'h0, dc, nb, res);
        check_vec("t3_bubbles", nb, 3);
        check_vec("t3_done_cyc", dc, 25);
        check_vec("t3_result", res[127:0] ^ res[255:128], EXP1);
        @(posedge ClkxCI); #1;

        // Second start mid-run must be ignored
        run_a({128'h0, BASE}, 0, -1, 8, {128'h0, ALL53}, dc, nb, res);
        check_vec("t4_done_cyc", dc, 22);
        check_vec("t4_result", res[127:0] ^ res[255:128], EXP1);
        @(posedge ClkxCI); #1;

        // Reset during operation, then a fresh start
        spurious = 0;
        startA = 1'b1;
        stateInA = {128'h0, ALL53};
        @(posedge ClkxCI); #1;
        startA = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            if (doneA) spurious++;
            rstA = (n == 10);
            if (n == 11) begin
                check_vec("t5_rst_busy", busyA, 1'b0);
                check_vec("t5_rst_rndreq", rndReqA, 1'b0);
                check_vec("t5_rst_sboxin", sboxInA, 16'h0);
                check_vec("t5_rst_state", stateOutA, 256'h0);
            end
            @(posedge ClkxCI); #1;
        end
        rstA = 1'b0;
        if (doneA) spurious++;
        check_vec("t5_no_done", spurious, 0);
        run_a({128'h0, BASE}, 0, -1, 0, 256'h0, dc, nb, res);
        check_vec("t5_done_cyc", 12 + dc, 34);
        check_vec("t5_result", res[127:0] ^ res[255:128], EXP1);

        // Three shares, latency 6
        m1 = {$urandom, $urandom, $urandom, $urandom};
        m2 = {$urandom, $urandom, $urandom, $urandom};
        dc = 0;
        resB = 384'h0;
        startB = 1'b1;
        stateInB = {m2, m1, BASE ^ m1 ^ m2};
        @(posedge ClkxCI); #1;
        startB = 1'b0;
        check_vec("t6_rndreq", rndReqB, 1'b1);
        for (int n = 1; n <= 60 && dc == 0; n++) begin
            if (doneB) begin
                dc = n;
                resB = stateOutB;
            end
            if (dc == 0) begin
                @(posedge ClkxCI); #1;
            end
        end
        check_vec("t6_done_cyc", dc, 23);
        check_vec("t6_result", resB[127:0] ^ resB[255:128] ^ resB[383:256], EXP1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
